// File: rtl/lever_frame_decoder_if.sv
// lever_frame_decoder_if: byte stream in, decoded lever channels and status out
interface lever_frame_decoder_if #(
    parameter int NUM_CH   = 2,
    parameter int CH_WIDTH = 16
);
    logic [7:0]                 byte_in;
    logic                       byte_valid;
    logic [NUM_CH*CH_WIDTH-1:0] al_bits;
    logic                       frame_ok;
    logic                       frame_err;
    logic                       timeout;
    logic                       link_ok;
    logic [7:0]                 err_count;
    logic [7:0]                 frame_count;
    logic [3:0]                 db_estado;

    modport master (
        output byte_in, byte_valid,
        input  al_bits, frame_ok, frame_err, timeout, link_ok, err_count, frame_count, db_estado
    );

    modport slave (
        input  byte_in, byte_valid,
        output al_bits, frame_ok, frame_err, timeout, link_ok, err_count, frame_count, db_estado
    );
endinterface

// File: rtl/lever_frame_decoder.sv
// lever_frame_decoder: sync-framed, XOR-checksummed multi-channel lever packet decoder
module lever_frame_decoder #(
    parameter int         NUM_CH         = 2,
    parameter int         CH_WIDTH       = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter int         STALE_CYCLES   = 5000000,
    parameter bit         ZERO_ON_STALE  = 1'b1
) (
    input logic                  clock,
    input logic                  reset,
    lever_frame_decoder_if.slave bus
);
    localparam int BPC = CH_WIDTH / 8;
    localparam int NB  = NUM_CH * BPC;
    localparam int W   = NUM_CH * CH_WIDTH;
    localparam int IW  = $clog2(NB + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW  = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHK = 2'd2} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_acc;
    logic [W-1:0]  r_shadow, r_al;
    logic [TW-1:0] r_tcnt;
    logic [SW-1:0] r_scnt;
    logic          r_ok, r_err, r_to, r_link;
    logic [7:0]    r_ec, r_fc;
    logic          w_commit, w_bad, w_tout, w_stale;

    // Decode this cycle's events and pick the next state; a byte always beats a timeout
    always_comb begin
        w_next   = r_state;
        w_tout   = (r_state != IDLE) && !bus.byte_valid && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
        w_commit = (r_state == CHK) && bus.byte_valid && (bus.byte_in == r_acc);
        w_bad    = (r_state == CHK) && bus.byte_valid && (bus.byte_in != r_acc);
        w_stale  = !w_commit && (r_scnt >= SW'(STALE_CYCLES - 1));
        if (w_tout)
            w_next = IDLE;
        else if (bus.byte_valid)
            w_next = (r_state == IDLE) ? ((bus.byte_in == SYNC_BYTE) ? RECV : IDLE) :
                     (r_state == RECV) ? ((r_idx == IW'(NB - 1)) ? CHK : RECV) : IDLE;
    end

    // State register
    always_ff @(posedge clock) begin
        r_state <= reset ? IDLE : w_next;
    end

    // Frame assembly: payload bytes land in the shadow at their channel/byte slot, MSB byte first
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx    <= '0;
            r_acc    <= '0;
            r_shadow <= '0;
        end else if (bus.byte_valid && r_state == IDLE) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (bus.byte_valid && r_state == RECV) begin
            r_idx <= r_idx + 1'b1;
            r_acc <= r_acc ^ bus.byte_in;
            for (int j = 0; j < NB; j++)
                if (r_idx == IW'(j))
                    r_shadow[((j / BPC) * BPC + BPC - 1 - (j % BPC)) * 8 +: 8] <= bus.byte_in;
        end
    end

    // Inter-byte idle counter, only live while a frame is in progress
    always_ff @(posedge clock) begin
        r_tcnt <= (reset || r_state == IDLE || bus.byte_valid || w_tout) ? '0 : r_tcnt + 1'b1;
    end

    // Cycles since the last good frame, saturating at the stale threshold
    always_ff @(posedge clock) begin
        r_scnt <= (reset || w_commit) ? '0 : (r_scnt == SW'(STALE_CYCLES)) ? r_scnt : r_scnt + 1'b1;
    end

    // Channel outputs, link flag, event pulses and statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            r_al   <= '0;
            r_link <= 1'b0;
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
            r_to   <= 1'b0;
            r_ec   <= '0;
            r_fc   <= '0;
        end else begin
            r_al   <= w_commit ? r_shadow : (ZERO_ON_STALE && w_stale) ? '0 : r_al;
            r_link <= w_commit | (r_link & ~w_stale);
            r_ok   <= w_commit;
            r_err  <= w_bad;
            r_to   <= w_tout;
            r_ec   <= ((w_bad || w_tout) && r_ec != 8'hFF) ? r_ec + 1'b1 : r_ec;
            r_fc   <= r_fc + {7'd0, w_commit};
        end
    end

    assign bus.al_bits     = r_al;
    assign bus.frame_ok    = r_ok;
    assign bus.frame_err   = r_err;
    assign bus.timeout     = r_to;
    assign bus.link_ok     = r_link;
    assign bus.err_count   = r_ec;
    assign bus.frame_count = r_fc;
    assign bus.db_estado   = {2'b00, r_state};
endmodule
